mem_access: RTL and testbench
=============================

# mem_access

Memory-access pipeline stage of the NPC core, between execute and writeback. It accepts one instruction at a time from execute and runs a load or store on the data bus through a request/acknowledge handshake. Load data is aligned and sign- or zero-extended here. The stage presents a registered result to writeback (`exc_data`, `mem_data`, `isloadEnable`, `rd`) under a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

## Interface
- `XLEN`, 64, datapath width; only 64 is supported (8 byte lanes).
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute presents an instruction.
- `in_ready` out 1: stage accepts the instruction on this edge.
- `in_exc_data` in XLEN: ALU result; this is the address for loads and stores.
- `in_store_data` in XLEN: store operand, right-justified.
- `in_is_load`, `in_is_store` in 1 each: never both high.
- `in_size` in 2: 00 byte, 01 half, 10 word, 11 dword.
- `in_unsigned` in 1: zero-extend load data (LBU/LHU/LWU).
- `in_rd` in 5, `in_rd_wen` in 1: destination register.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out XLEN (bits [2:0] = 0), `bus_wdata` out XLEN, `bus_wstrb` out 8.
- `bus_ack` in 1, `bus_rdata` in XLEN.
- `out_valid` out 1, `out_ready` in 1.
- `out_exc_data` out XLEN, `out_mem_data` out XLEN, `out_isloadEnable` out 1, `out_rd` out 5, `out_rd_wen` out 1.
- `out_misalign` out 1: present only with `MEM_MISALIGN_CHECK_EN`.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - BUS: `bus_req` high, waiting for `bus_ack`.
  - HOLD: result registered, waiting for writeback.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- Accept in IDLE, non-memory instruction: load the output registers, `out_valid`=1, `out_isloadEnable`=0, `out_mem_data`=0; state stays IDLE.
- Accept in IDLE, load or store: latch request fields, go to BUS, and clear `out_valid` in the same edge.
- Bus address: `bus_addr` = {addr[XLEN-1:3], 3'b0}; byte offset `off` = addr[2:0].
- Store strobes: `bus_wstrb` = mask(size) << off, with masks 0x01 / 0x03 / 0x0F / 0xFF.
- Store data: `bus_wdata` = store_data << (off*8); `bus_we`=1.
- Load: `bus_we`=0 and `bus_wstrb`=0xFF.
- Load data: raw = `bus_rdata` >> (off*8), truncated to the size, then sign-extended or zero-extended per `in_unsigned`. Dword loads are never extended.
- BUS state rules:
  - `bus_req`, `bus_addr`, `bus_we`, `bus_wdata` and `bus_wstrb` are held stable until `bus_ack`.
  - `bus_ack` is ignored while `bus_req`=0.
- On `bus_ack`, register the result, go to HOLD with `out_valid`=1.
  - Load: `out_isloadEnable` = `in_rd_wen`.
  - Store: `out_isloadEnable`=0 and `out_rd_wen`=0.
- HOLD: when `out_ready`=1, go to IDLE with `out_valid`=0 at that edge.
- Misaligned access without the check feature: bytes past the dword boundary are dropped from `bus_wstrb` and `bus_wdata` (the shift truncates them). The load result is the truncated shift value, then extended.

## Timing
- Reset: state=IDLE, `out_valid`=0, `bus_req`=0, `bus_we`=0, `bus_wstrb`=0, and all data/address outputs 0.
- Non-memory latency: accepted at edge N, `out_valid` high from N+1.
- Memory latency: `bus_req` high from N+1; an ack sampled at edge K gives `out_valid` from K+1. With a zero-wait ack the latency is 2.
- Back-to-back non-memory: one per cycle while `out_ready`=1.
- Output stall: `out_*` are held unchanged while `out_valid` && !`out_ready`.
- Reset mid-transaction: `bus_req` drops at the reset edge and the access is discarded. A later `bus_ack` is ignored because `bus_req`=0.
- `in_valid` && `in_ready` together with `out_ready` in the same cycle: the old output retires and the new one loads on the same edge.

## Configuration
- Macro: `MEM_MISALIGN_CHECK_EN`.
- Defined:
  - Any access with addr[0]!=0 for half, addr[1:0]!=0 for word, or addr[2:0]!=0 for dword issues no bus request.
  - It goes straight to an output with `out_valid`=1 at N+1, `out_misalign`=1, `out_rd_wen`=0 and `out_isloadEnable`=0.
  - `out_misalign` is cleared on every other result.
- Undefined: the `out_misalign` port is absent and misaligned accesses follow the truncation rule under Operation.

## Structure
- Shared header (the existing system config include): `XLEN`, the size encodings `MEM_B`/`MEM_H`/`MEM_W`/`MEM_D`, and the FSM state encodings.
- Sub-module `load_align` (combinational):
  - Inputs: rdata, off, size, unsigned.
  - Output: the extended XLEN result.
  - Instantiated once; verified standalone.

## Test plan
- Reset, then `in_valid` with a non-memory instruction, `in_exc_data`=0x1234 and rd=5: `out_valid` at the next cycle, `out_exc_data`=0x1234, `out_isloadEnable`=0.
- LB at addr 0x8000_0003, `bus_rdata`=0x0000_0000_8000_0000, ack after 3 cycles:
  - `bus_addr`=0x8000_0000.
  - `out_mem_data`=0xFFFF_FFFF_FFFF_FF80.
  - LBU of the same gives 0x80.
- SH at addr 0x...06 with data 0xABCD: `bus_wstrb`=0xC0, `bus_wdata`=0xABCD_0000_0000_0000, `bus_we`=1, `out_rd_wen`=0.
- Hold `out_ready`=0 for 4 cycles after a load completes:
  - Outputs stay stable and `in_ready`=0.
  - On release, the next instruction is accepted on the same edge.
- Assert `rst` while in BUS:
  - `bus_req`=0 at the next edge.
  - A late `bus_ack` produces no `out_valid`.
- With `MEM_MISALIGN_CHECK_EN`, LW at 0x...02: no `bus_req`, `out_misalign`=1 at N+1, `out_rd_wen`=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the mem_access stage: datapath width, access size
// encodings, FSM states and small helpers.
package mem_access_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_D = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        HOLD = 2'b10
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (mem_size_e'(size))
            MEM_B:   return 8'h01;
            MEM_H:   return 8'h03;
            MEM_W:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (mem_size_e'(size))
            MEM_H:   return off[0];
            MEM_W:   return |off[1:0];
            MEM_D:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge interface between mem_access (master) and memory (slave).
interface mem_access_if;

    logic                             bus_req;
    logic                             bus_we;
    logic [mem_access_pkg::XLEN-1:0] bus_addr;
    logic [mem_access_pkg::XLEN-1:0] bus_wdata;
    logic [7:0]                       bus_wstrb;
    logic                             bus_ack;
    logic [mem_access_pkg::XLEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_load_align.sv
// load_align: shifts the raw bus dword down to the access offset, truncates
// to the access size and sign- or zero-extends the result.
module load_align
    import mem_access_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [1:0]      size,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        result  = shifted;
        case (mem_size_e'(size))
            MEM_B: result = load_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                          : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MEM_H: result = load_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_W: result = load_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                          : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between execute and writeback.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (misaligned accesses skip the bus and flag out_misalign).
module mem_access
    import mem_access_pkg::*;
(
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_exc_data,
    input  logic [XLEN-1:0] in_store_data,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,

    mem_access_if.master    bus,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_exc_data,
    output logic [XLEN-1:0] out_mem_data,
    output logic            out_isloadEnable,
    output logic [4:0]      out_rd,
    output logic            out_rd_wen
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic            out_misalign
`endif
);

    state_e          state_q, state_d;

    logic [XLEN-1:0] req_addr_q;
    logic [1:0]      req_size_q;
    logic            req_unsigned_q;
    logic            req_load_q;
    logic [4:0]      req_rd_q;
    logic            req_rd_wen_q;

    logic            accept;
    logic            is_mem;
    logic            misalign;
    logic            start_bus;
    logic            ack;
    logic [XLEN-1:0] load_result;

    load_align u_load_align (
        .rdata         (bus.bus_rdata),
        .off           (req_addr_q[2:0]),
        .size          (req_size_q),
        .load_unsigned (req_unsigned_q),
        .result        (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        is_mem    = in_is_load || in_is_store;
        misalign  = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign  = is_mem && is_misaligned(in_size, in_exc_data[2:0]);
`endif
        start_bus = accept && is_mem && !misalign;
        ack       = (state_q == BUS) && bus.bus_req && bus.bus_ack;

        case (state_q)
            IDLE:    if (start_bus) state_d = BUS;
            BUS:     if (ack)       state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bus_req      <= 1'b0;
            bus.bus_we       <= 1'b0;
            bus.bus_addr     <= '0;
            bus.bus_wdata    <= '0;
            bus.bus_wstrb    <= '0;
            req_addr_q       <= '0;
            req_size_q       <= '0;
            req_unsigned_q   <= 1'b0;
            req_load_q       <= 1'b0;
            req_rd_q         <= '0;
            req_rd_wen_q     <= 1'b0;
            out_valid        <= 1'b0;
            out_exc_data     <= '0;
            out_mem_data     <= '0;
            out_isloadEnable <= 1'b0;
            out_rd           <= '0;
            out_rd_wen       <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            out_misalign     <= 1'b0;
`endif
        end else begin
            // Retire first; a same-edge accept or ack below overrides this.
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (start_bus) begin
                bus.bus_req    <= 1'b1;
                bus.bus_we     <= in_is_store;
                bus.bus_addr   <= {in_exc_data[XLEN-1:3], 3'b000};
                bus.bus_wdata  <= in_is_store ? (in_store_data << {in_exc_data[2:0], 3'b000}) : '0;
                bus.bus_wstrb  <= in_is_store ? 8'(size_mask(in_size) << in_exc_data[2:0]) : 8'hFF;
                req_addr_q     <= in_exc_data;
                req_size_q     <= in_size;
                req_unsigned_q <= in_unsigned;
                req_load_q     <= in_is_load;
                req_rd_q       <= in_rd;
                req_rd_wen_q   <= in_rd_wen;
                out_valid      <= 1'b0;
            end else if (accept) begin
                out_valid        <= 1'b1;
                out_exc_data     <= in_exc_data;
                out_mem_data     <= '0;
                out_isloadEnable <= 1'b0;
                out_rd           <= in_rd;
                out_rd_wen       <= in_rd_wen && !misalign;
`ifdef MEM_MISALIGN_CHECK_EN
                out_misalign     <= misalign;
`endif
            end

            if (ack) begin
                bus.bus_req      <= 1'b0;
                out_valid        <= 1'b1;
                out_exc_data     <= req_addr_q;
                out_mem_data     <= req_load_q ? load_result : '0;
                out_isloadEnable <= req_load_q && req_rd_wen_q;
                out_rd           <= req_rd_q;
                out_rd_wen       <= req_load_q && req_rd_wen_q;
`ifdef MEM_MISALIGN_CHECK_EN
                out_misalign     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// transactions checked against a byte-lane reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_exc_data;
    logic [63:0] in_store_data;
    logic        in_is_load;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_exc_data;
    logic [63:0] out_mem_data;
    logic        out_isloadEnable;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        out_misalign;
`endif

    int checks = 0;
    int errors = 0;

    mem_access_if bus_if ();

    mem_access dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_exc_data      (in_exc_data),
        .in_store_data    (in_store_data),
        .in_is_load       (in_is_load),
        .in_is_store      (in_is_store),
        .in_size          (in_size),
        .in_unsigned      (in_unsigned),
        .in_rd            (in_rd),
        .in_rd_wen        (in_rd_wen),
        .bus              (bus_if.master),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_exc_data     (out_exc_data),
        .out_mem_data     (out_mem_data),
        .out_isloadEnable (out_isloadEnable),
        .out_rd           (out_rd),
        .out_rd_wen       (out_rd_wen)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .out_misalign     (out_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int n_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    // Gather the accessed bytes lane by lane, dropping any past the dword end.
    function automatic logic [63:0] m_load(input logic [63:0] rdata, input int off,
                                           input logic [1:0] size, input logic uns);
        logic [63:0] v;
        int n;
        v = '0;
        n = n_bytes(size);
        for (int b = 0; b < n; b++)
            if (off + b < 8) v[8*b +: 8] = rdata[8*(off+b) +: 8];
        if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    function automatic logic [7:0] m_wstrb(input int off, input logic [1:0] size);
        logic [7:0] s;
        s = '0;
        for (int b = 0; b < n_bytes(size); b++)
            if (off + b < 8) s[off+b] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input int off, input logic [63:0] sdata);
        logic [63:0] w;
        w = '0;
        for (int lane = 0; lane < 8; lane++)
            if (lane >= off) w[8*lane +: 8] = sdata[8*(lane-off) +: 8];
        return w;
    endfunction

    task automatic do_nonmem(input logic [63:0] data, input logic [4:0] rd, input logic wen);
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0;
        in_exc_data = data; in_rd = rd; in_rd_wen = wen;
        in_store_data = {$urandom, $urandom}; in_size = 2'($urandom); out_ready = 1'b1;
        #1 check("nm_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("nm_out_valid", out_valid, 1'b1);
        check("nm_exc_data", out_exc_data, data);
        check("nm_mem_data", out_mem_data, 64'd0);
        check("nm_isload", out_isloadEnable, 1'b0);
        check("nm_rd", out_rd, rd);
        check("nm_rd_wen", out_rd_wen, wen);
`ifdef MEM_MISALIGN_CHECK_EN
        check("nm_misalign", out_misalign, 1'b0);
`endif
        @(negedge clk);
        check("nm_retire", out_valid, 1'b0);
    endtask

    task automatic do_mem(input logic is_load, input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [1:0] size, input logic uns, input logic [4:0] rd,
                          input logic wen, input logic [63:0] rdata, input int wt, input int stall,
                          output logic [63:0] got_data, output logic [63:0] got_addr,
                          output logic [7:0] got_wstrb, output logic [63:0] got_wdata);
        logic        mis;
        logic [63:0] exp_data;
        logic [63:0] exp_addr;
        logic        exp_wen;
        int          off;
        off      = int'(addr[2:0]);
        mis      = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis      = (off % n_bytes(size)) != 0;
`endif
        exp_data  = is_load ? m_load(rdata, off, size, uns) : 64'd0;
        exp_addr  = {addr[63:3], 3'b000};
        exp_wen   = is_load && wen;
        got_data  = '0; got_addr = '0; got_wstrb = '0; got_wdata = '0;

        in_valid = 1'b1; in_is_load = is_load; in_is_store = !is_load;
        in_exc_data = addr; in_store_data = sdata; in_size = size; in_unsigned = uns;
        in_rd = rd; in_rd_wen = wen; out_ready = 1'b1;
        #1 check("mem_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;

        if (mis) begin
            check("mis_bus_req", bus_if.bus_req, 1'b0);
            check("mis_out_valid", out_valid, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
            check("mis_flag", out_misalign, 1'b1);
`endif
            check("mis_rd_wen", out_rd_wen, 1'b0);
            check("mis_isload", out_isloadEnable, 1'b0);
            @(negedge clk);
            check("mis_retire", out_valid, 1'b0);
            return;
        end

        got_addr  = bus_if.bus_addr;
        got_wstrb = bus_if.bus_wstrb;
        got_wdata = bus_if.bus_wdata;
        check("bus_req", bus_if.bus_req, 1'b1);
        check("bus_out_valid", out_valid, 1'b0);
        check("bus_addr", bus_if.bus_addr, exp_addr);
        check("bus_we", bus_if.bus_we, !is_load);
        check("bus_wstrb", bus_if.bus_wstrb, is_load ? 8'hFF : m_wstrb(off, size));
        if (!is_load) check("bus_wdata", bus_if.bus_wdata, m_wdata(off, sdata));

        for (int i = 0; i < wt; i++) begin
            @(negedge clk);
            check("wait_bus_req", bus_if.bus_req, 1'b1);
            check("wait_bus_addr", bus_if.bus_addr, exp_addr);
            check("wait_out_valid", out_valid, 1'b0);
        end

        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata;
        if (stall > 0) out_ready = 1'b0;
        @(negedge clk);
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = {$urandom, $urandom};
        got_data = out_mem_data;
        check("ack_out_valid", out_valid, 1'b1);
        check("ack_bus_req", bus_if.bus_req, 1'b0);
        check("ack_exc_data", out_exc_data, addr);
        check("ack_mem_data", out_mem_data, exp_data);
        check("ack_isload", out_isloadEnable, exp_wen);
        check("ack_rd_wen", out_rd_wen, exp_wen);
        check("ack_rd", out_rd, rd);
`ifdef MEM_MISALIGN_CHECK_EN
        check("ack_misalign", out_misalign, 1'b0);
`endif

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_mem_data", out_mem_data, exp_data);
            check("stall_exc_data", out_exc_data, addr);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_retire", out_valid, 1'b0);
        check("hold_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] gd, ga, gw, d;
        logic [7:0]  gs;
        logic        kl;

        rst = 1'b1; in_valid = 1'b0; in_exc_data = '0; in_store_data = '0;
        in_is_load = 1'b0; in_is_store = 1'b0; in_size = '0; in_unsigned = 1'b0;
        in_rd = '0; in_rd_wen = 1'b0; out_ready = 1'b1;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_bus_req", bus_if.bus_req, 1'b0);
        check("rst_bus_we", bus_if.bus_we, 1'b0);
        check("rst_bus_wstrb", bus_if.bus_wstrb, 8'h00);
        check("rst_bus_addr", bus_if.bus_addr, 64'd0);
        check("rst_out_exc", out_exc_data, 64'd0);
        check("rst_out_mem", out_mem_data, 64'd0);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1'b1);

        do_nonmem(64'h1234, 5'd5, 1'b1);

        do_mem(1'b1, 64'h8000_0003, '0, 2'b00, 1'b0, 5'd7, 1'b1,
               64'h0000_0000_8000_0000, 3, 0, gd, ga, gs, gw);
        check("lb_addr", ga, 64'h8000_0000);
        check("lb_data", gd, 64'hFFFF_FFFF_FFFF_FF80);
        do_mem(1'b1, 64'h8000_0003, '0, 2'b00, 1'b1, 5'd7, 1'b1,
               64'h0000_0000_8000_0000, 3, 0, gd, ga, gs, gw);
        check("lbu_data", gd, 64'h80);

        do_mem(1'b0, 64'h1006, 64'hABCD, 2'b01, 1'b0, 5'd3, 1'b1,
               '0, 1, 0, gd, ga, gs, gw);
        check("sh_wstrb", gs, 8'hC0);
        check("sh_wdata", gw, 64'hABCD_0000_0000_0000);

        // Load result held under writeback backpressure.
        do_mem(1'b1, 64'h2008, '0, 2'b11, 1'b0, 5'd9, 1'b1,
               64'h0123_4567_89AB_CDEF, 0, 4, gd, ga, gs, gw);
        check("ld_data", gd, 64'h0123_4567_89AB_CDEF);

        // Non-memory stall, then retire-and-accept on one edge.
        in_valid = 1'b1; in_exc_data = 64'hAAAA; in_rd = 5'd1; in_rd_wen = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("nstall_valid", out_valid, 1'b1);
            check("nstall_in_ready", in_ready, 1'b0);
            check("nstall_exc", out_exc_data, 64'hAAAA);
        end
        in_valid = 1'b1; in_exc_data = 64'hBBBB; out_ready = 1'b1;
        #1 check("same_edge_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("same_edge_valid", out_valid, 1'b1);
        check("same_edge_exc", out_exc_data, 64'hBBBB);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            in_valid = 1'b1; in_exc_data = d; in_rd = 5'(i);
            #1 check("b2b_in_ready", in_ready, 1'b1);
            @(negedge clk);
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_exc", out_exc_data, d);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_retire", out_valid, 1'b0);

        // Reset while the bus access is outstanding.
        in_valid = 1'b1; in_is_load = 1'b1; in_exc_data = 64'h3000; in_size = 2'b11;
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'b0;
        check("rb_req", bus_if.bus_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rb_req_drop", bus_if.bus_req, 1'b0);
        check("rb_valid", out_valid, 1'b0);
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        check("late_ack_valid", out_valid, 1'b0);
        check("late_ack_req", bus_if.bus_req, 1'b0);
        @(negedge clk);
        check("late_ack_valid2", out_valid, 1'b0);

`ifdef MEM_MISALIGN_CHECK_EN
        do_mem(1'b1, 64'h1002, '0, 2'b10, 1'b0, 5'd4, 1'b1,
               '0, 0, 0, gd, ga, gs, gw);
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_nonmem({$urandom, $urandom}, 5'($urandom), 1'($urandom));
            end else begin
                kl = 1'($urandom);
                do_mem(kl, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom),
                       1'($urandom), 5'($urandom), 1'($urandom), {$urandom, $urandom},
                       $urandom_range(0, 3), $urandom_range(0, 2), gd, ga, gs, gw);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
